alto_muldiv_seq: RTL and testbench

ALTO_MULDIV_SEQ -- requirements
Module: alto_muldiv_seq

---
 rtl/alto_muldiv_pkg.sv | 30 +++
 rtl/alto_muldiv_seq.sv | 156 +++++++++++++++
 tb/tb_alto_muldiv_seq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alto_muldiv_pkg.sv
// Shared definitions for the Alto sequential multiply/divide unit.
// ALU function codes and controller state encoding.
package alto_muldiv_pkg;

  localparam int W     = 16;
  localparam int STEPS = 16;
  localparam int CW    = 4;

  localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);

  typedef enum logic [3:0] {
    ALUF_BUS         = 4'h0,
    ALUF_T           = 4'h1,
    ALUF_BUS_OR_T    = 4'h2,
    ALUF_BUS_AND_T   = 4'h3,
    ALUF_BUS_XOR_T   = 4'h4,
    ALUF_BUS_PLUS_1  = 4'h5,
    ALUF_BUS_MINUS_1 = 4'h6,
    ALUF_BUS_PLUS_T  = 4'h7,
    ALUF_BUS_MINUS_T = 4'h8
  } aluf_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_STEP  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/alto_muldiv_seq.sv
// Sequential 16x16 multiply / 32/16 divide driving an external shared ALU.
// Divide path is built only when ALTO_MULDIV_DIV_EN is defined.
module alto_muldiv_seq
  import alto_muldiv_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic         op_i,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] opnd_i,
  output logic [3:0]   alu_aluf_o,
  output logic [W-1:0] alu_bus_o,
  output logic [W-1:0] alu_t_o,
  output logic         alu_skip_o,
  input  logic [W-1:0] alu_result_i,
  input  logic         alu_carry_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         ovf_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  state_e        state_q, state_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  aluf_e         aluf;
  logic          mul_c;
`ifdef ALTO_MULDIV_DIV_EN
  logic          op_q, op_d;
  logic          div_sub;
`endif

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef ALTO_MULDIV_DIV_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
`ifdef ALTO_MULDIV_DIV_EN
      op_q    <= op_d;
`endif
    end
  end

  // Next state, ALU control and step datapath
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    aluf      = ALUF_BUS;
    alu_bus_o = '0;
    alu_t_o   = '0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    mul_c     = 1'b0;
`ifdef ALTO_MULDIV_DIV_EN
    op_d      = op_q;
    div_sub   = 1'b0;
`endif
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (start_i) begin
          hi_d  = hi_i;
          lo_d  = lo_i;
          d_d   = opnd_i;
          ovf_d = 1'b0;
          cnt_d = '0;
`ifdef ALTO_MULDIV_DIV_EN
          op_d    = op_i;
          state_d = op_i ? S_CHECK : S_STEP;
`else
          if (op_i) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_STEP;
          end
`endif
        end
      end
      state_q == S_CHECK: begin
`ifdef ALTO_MULDIV_DIV_EN
        busy_o    = 1'b1;
        aluf      = ALUF_BUS_MINUS_T;
        alu_bus_o = hi_q;
        alu_t_o   = d_q;
        if (alu_carry_i) begin
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_STEP;
        end
`else
        state_d = S_IDLE;
`endif
      end
      state_q == S_STEP: begin
        busy_o  = 1'b1;
        alu_t_o = d_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST)
          state_d = S_DONE;
`ifdef ALTO_MULDIV_DIV_EN
        if (op_q) begin
          aluf      = ALUF_BUS_MINUS_T;
          alu_bus_o = {hi_q[W-2:0], lo_q[W-1]};
          div_sub   = hi_q[W-1] | alu_carry_i;
          hi_d      = div_sub ? alu_result_i : alu_bus_o;
          lo_d      = {lo_q[W-2:0], div_sub};
        end else begin
`endif
          aluf         = lo_q[0] ? ALUF_BUS_PLUS_T : ALUF_BUS;
          alu_bus_o    = hi_q;
          mul_c        = lo_q[0] & alu_carry_i;
          {hi_d, lo_d} = {mul_c, alu_result_i, lo_q[W-1:1]};
`ifdef ALTO_MULDIV_DIV_EN
        end
`endif
      end
      state_q == S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign alu_aluf_o = aluf;
  assign alu_skip_o = 1'b0;
  assign ovf_o      = ovf_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_alto_muldiv_seq.sv
// Bench for alto_muldiv_seq: models the shared ALU, runs vector table,
// randomized ops vs. arithmetic reference, reset and held-start sequences.
module tb_alto_muldiv_seq;

  localparam logic [3:0] F_BUS   = 4'h0;
  localparam logic [3:0] F_PLUS  = 4'h7;
  localparam logic [3:0] F_MINUS = 4'h8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] hi = '0, lo = '0, opnd = '0;
  logic [3:0]  alu_aluf;
  logic [15:0] alu_bus, alu_t, alu_result;
  logic        alu_skip, alu_carry;
  logic        busy, done, ovf;
  logic [15:0] hi_o, lo_o;
  logic [16:0] alu_sum;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alto_muldiv_seq dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .op_i         (op),
    .hi_i         (hi),
    .lo_i         (lo),
    .opnd_i       (opnd),
    .alu_aluf_o   (alu_aluf),
    .alu_bus_o    (alu_bus),
    .alu_t_o      (alu_t),
    .alu_skip_o   (alu_skip),
    .alu_result_i (alu_result),
    .alu_carry_i  (alu_carry),
    .busy_o       (busy),
    .done_o       (done),
    .ovf_o        (ovf),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  // Behavioural shared ALU
  always_comb begin
    alu_sum = {1'b0, alu_bus};
    case (alu_aluf)
      F_PLUS:  alu_sum = {1'b0, alu_bus} + {1'b0, alu_t};
      F_MINUS: alu_sum = {1'b0, alu_bus} + {1'b0, ~alu_t} + 17'd1;
      default: alu_sum = {1'b0, alu_bus};
    endcase
  end
  assign alu_result = alu_sum[15:0];
  assign alu_carry  = (alu_aluf == F_BUS) ? 1'b0 : alu_sum[16];

  typedef struct {
    string       name;
    logic        op;
    logic [15:0] hi, lo, opnd;
    logic [15:0] eh, el;
    logic        eovf;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic ref_op(input logic o, input logic [15:0] h, l, d,
                        output logic [15:0] rh, rl,
                        output logic rovf, output int lat);
    logic [31:0] p, q, r;
    rovf = 1'b0;
    rh = h;
    rl = l;
    if (!o) begin
      p = 32'(h) + 32'(l) * 32'(d);
      rh = p[31:16];
      rl = p[15:0];
      lat = 17;
    end else begin
`ifdef ALTO_MULDIV_DIV_EN
      if (h >= d) begin
        rovf = 1'b1;
        lat = 2;
      end else begin
        q = {h, l} / 32'(d);
        r = {h, l} % 32'(d);
        rl = q[15:0];
        rh = r[15:0];
        lat = 18;
      end
`else
      rovf = 1'b1;
      lat = 1;
`endif
    end
  endtask

  task automatic run_op(input string nm, input logic o,
                        input logic [15:0] h, l, d,
                        input logic [15:0] eh, el,
                        input logic eovf, input int elat);
    int got;
    @(negedge clk);
    start = 1'b1;
    op = o;
    hi = h;
    lo = l;
    opnd = d;
    @(posedge clk);
    #1 start = 1'b0;
    got = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        got = n;
        break;
      end
    end
    chk({nm, " latency"}, got, elat);
    chk({nm, " hi"}, hi_o, eh);
    chk({nm, " lo"}, lo_o, el);
    chk({nm, " ovf"}, ovf, eovf);
    @(negedge clk);
    chk({nm, " pulse"}, {busy, done}, 2'b00);
    chk({nm, " ovf held"}, ovf, eovf);
  endtask

  initial begin
    logic [15:0] rh, rl, h, l, d;
    logic        rovf, o;
    int          lat, first, second;

    vecs[0] = '{"mul3x5", 1'b0, 16'h0000, 16'h0003, 16'h0005,
                16'h0000, 16'h000F, 1'b0, 17};
    vecs[1] = '{"mulmax", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                16'hFFFF, 16'h0000, 1'b0, 17};
    vecs[2] = '{"mulzero", 1'b0, 16'h1234, 16'h0000, 16'hABCD,
                16'h0000, 16'h1234, 1'b0, 17};
`ifdef ALTO_MULDIV_DIV_EN
    vecs[3] = '{"div3", 1'b1, 16'h0001, 16'h0000, 16'h0003,
                16'h0001, 16'h5555, 1'b0, 18};
    vecs[4] = '{"divovf", 1'b1, 16'h0005, 16'h1234, 16'h0005,
                16'h0005, 16'h1234, 1'b1, 2};
    vecs[5] = '{"divzero", 1'b1, 16'h0005, 16'h1234, 16'h0000,
                16'h0005, 16'h1234, 1'b1, 2};
    vecs[6] = '{"divone", 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF,
                16'h0000, 16'h0001, 1'b0, 18};
    vecs[7] = '{"divbig", 1'b1, 16'hFFFE, 16'hFFFF, 16'hFFFF,
                16'hFFFE, 16'hFFFF, 1'b0, 18};
`else
    vecs[3] = '{"div3", 1'b1, 16'h0001, 16'h0000, 16'h0003,
                16'h0001, 16'h0000, 1'b1, 1};
    vecs[4] = '{"divovf", 1'b1, 16'h0005, 16'h1234, 16'h0005,
                16'h0005, 16'h1234, 1'b1, 1};
    vecs[5] = '{"divzero", 1'b1, 16'h0005, 16'h1234, 16'h0000,
                16'h0005, 16'h1234, 1'b1, 1};
    vecs[6] = '{"divone", 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF,
                16'h0000, 16'hFFFF, 1'b1, 1};
    vecs[7] = '{"divbig", 1'b1, 16'hFFFE, 16'hFFFF, 16'hFFFF,
                16'hFFFE, 16'hFFFF, 1'b1, 1};
`endif

    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst ovf", ovf, 1'b0);
    chk("rst hi", hi_o, 16'h0);
    chk("rst lo", lo_o, 16'h0);
    chk("rst aluf", alu_aluf, F_BUS);
    chk("rst bus/t", {alu_bus, alu_t}, 32'h0);
    chk("rst skip", alu_skip, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].hi, vecs[i].lo,
             vecs[i].opnd, vecs[i].eh, vecs[i].el, vecs[i].eovf,
             vecs[i].lat);

    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      l = 16'($urandom);
      h = 16'($urandom);
      if (o && (i % 4 != 0))
        h = (d == 16'h0) ? 16'h0 : 16'(h % d);
      ref_op(o, h, l, d, rh, rl, rovf, lat);
      run_op($sformatf("rand%0d", i), o, h, l, d, rh, rl, rovf, lat);
    end

    // Reset asserted during the 8th multiply step
    @(negedge clk);
    start = 1'b1;
    op = 1'b0;
    hi = 16'h0;
    lo = 16'h0003;
    opnd = 16'h0005;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk("mid busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst busy", busy, 1'b0);
    chk("arst done", done, 1'b0);
    chk("arst ovf", ovf, 1'b0);
    chk("arst hi/lo", {hi_o, lo_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("postrst", 1'b0, 16'h0, 16'h0003, 16'h0005,
           16'h0000, 16'h000F, 1'b0, 17);

    // start held high: one op per IDLE visit
    @(negedge clk);
    start = 1'b1;
    op = 1'b0;
    hi = 16'h0;
    lo = 16'h0003;
    opnd = 16'h0005;
    @(posedge clk);
    first = 0;
    second = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        if (first == 0) first = n;
        else if (second == 0) second = n;
      end
      if (n == 35) start = 1'b0;
    end
    chk("held first", first, 17);
    chk("held second", second, 35);
    chk("held result", {hi_o, lo_o}, 32'h0000_000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
